// File: rtl/alu_seq_pkg.sv
// Purpose: shared types and constants for the ALU sequencer (op codes, ALU control, FSM states).
// Latency: n/a (declarations and one combinational decode function only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_NOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // ALU_ctl: bit3 a-invert, bit2 b-invert (also carry-in), [1:0] and/or/add/slt
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_MUL  = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    // MUL maps to ADD because every shift-add step is an ALU add;
    // reserved maps to the idle encoding.
    function automatic logic [3:0] op_to_ctl(input op_e op);
        case (op)
            OP_AND:  return CTL_AND;
            OP_OR:   return CTL_OR;
            OP_ADD:  return CTL_ADD;
            OP_SUB:  return CTL_SUB;
            OP_SLT:  return CTL_SLT;
            OP_NOR:  return CTL_NOR;
            OP_MUL:  return CTL_ADD;
            default: return CTL_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Purpose: drives an external 32-bit ALU; single-pass ops in one pass, MUL as shift-add over ALU adds.
// Latency: response valid 2 cycles after accept, plus (msb index of b)+1 cycles for MUL with b!=0.
// Backpressure: req_ready only in IDLE; RESP holds its outputs until rsp_ready.
// Ports: clk/rstn (sync active-low); req_* request handshake; rsp_* registered response;
//        alu_a/alu_b/alu_ctl to the ALU, alu_result/alu_zero/alu_overflow back from it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow
);

    state_t           state_q, state_d;
    op_e              op_q, op_d;
    // m_q/q_q hold the latched a/b operands; for MUL they are the shifting
    // multiplicand and multiplier.
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        m_d          = m_q;
        q_d          = q_q;
        acc_d        = acc_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_ctl      = CTL_AND;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    m_d     = req_a;
                    q_d     = req_b;
                    acc_d   = '0;
                    state_d = (op_e'(req_op) == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_RSVD) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                    rsp_ovf_d    = 1'b0;
                end else begin
                    alu_a        = m_q;
                    alu_b        = q_q;
                    alu_ctl      = op_to_ctl(op_q);
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_ovf_d    = alu_overflow && (op_q == OP_ADD || op_q == OP_SUB);
                end
                state_d = ST_RESP;
            end
            ST_MUL: begin
                // Terminating on Q==0 rather than a fixed 32 steps makes latency
                // track the multiplier's highest set bit.
                if (q_q == '0) begin
                    rsp_result_d = acc_q;
                    rsp_zero_d   = (acc_q == '0);
                    rsp_ovf_d    = 1'b0;
                    state_d      = ST_RESP;
                end else begin
                    alu_a   = acc_q;
                    alu_b   = m_q;
                    alu_ctl = CTL_ADD;
                    if (q_q[0]) begin
                        acc_d = alu_result;
                    end
                    m_d = m_q << 1;
                    q_d = q_q >> 1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_AND;
            m_q          <= '0;
            q_q          <= '0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            m_q          <= m_d;
            q_q          <= q_d;
            acc_q        <= acc_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ovf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer with a behavioural ALU and arithmetic reference model.
// Latency: n/a.
// Backpressure: exercises rsp_ready held low for several cycles.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] ctl_tab [8];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctl      (alu_ctl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow)
    );

    // Stand-in for the external MIPS-style ALU.
    logic [31:0] aa, bb;
    logic [32:0] sum;
    logic        add_ovf;
    always_comb begin
        aa      = alu_ctl[3] ? ~alu_a : alu_a;
        bb      = alu_ctl[2] ? ~alu_b : alu_b;
        sum     = {1'b0, aa} + {1'b0, bb} + {32'd0, alu_ctl[2]};
        add_ovf = (aa[31] == bb[31]) && (sum[31] != aa[31]);
        case (alu_ctl[1:0])
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            2'b10:   alu_result = sum[31:0];
            default: alu_result = {31'd0, sum[31] ^ add_ovf};
        endcase
        alu_zero     = (alu_result == 32'd0);
        alu_overflow = (alu_ctl[1:0] == 2'b10) ? add_ovf : 1'b0;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a - b;
            3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5: return ~(a | b);
            3'd6: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = ref_result(op, a, b);
        if (op == 3'd2) return (a[31] == b[31]) && (r[31] != a[31]);
        if (op == 3'd3) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
        int hb;
        if (op != 3'd6 || b == 32'd0) return 2;
        hb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hb = i;
        return 3 + hb;
    endfunction

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eo;
        int          lat;
        int          seen;
        er   = ref_result(op, a, b);
        eo   = ref_ovf(op, a, b);
        lat  = ref_latency(op, b);
        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        // Garbage on the request bus proves operands were latched at accept.
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        seen = 0;
        for (int i = 1; i <= 40 && seen == 0; i++) begin
            @(negedge clk);
            if (i == 1 && !(op == 3'd6 && b == 32'd0))
                check_eq("ctl_first_cycle", {28'd0, alu_ctl}, {28'd0, ctl_tab[op]});
            if (rsp_valid) seen = i;
        end
        check_eq("latency", seen, lat);
        if (seen == 0) begin
            apply_reset();
        end else begin
            check_eq("result", rsp_result, er);
            check_eq("zero", {31'd0, rsp_zero}, {31'd0, er == 32'd0});
            check_eq("overflow", {31'd0, rsp_overflow}, {31'd0, eo});
            check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
                check_eq("hold_result", rsp_result, er);
                check_eq("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            check_eq("rsp_drop", {31'd0, rsp_valid}, 32'd0);
            check_eq("req_ready_back", {31'd0, req_ready}, 32'd1);
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int quiet_viol;
        logic [2:0] rop;
        logic [31:0] ra, rb;

        ctl_tab[0] = 4'b0000; ctl_tab[1] = 4'b0001; ctl_tab[2] = 4'b0010; ctl_tab[3] = 4'b0110;
        ctl_tab[4] = 4'b0111; ctl_tab[5] = 4'b1100; ctl_tab[6] = 4'b0010; ctl_tab[7] = 4'b0000;

        rstn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_result", rsp_result, 32'd0);
        check_eq("rst_zero", {31'd0, rsp_zero}, 32'd0);
        check_eq("rst_ovf", {31'd0, rsp_overflow}, 32'd0);
        check_eq("rst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        rstn = 1'b1;

        run_op(3'd2, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(3'd3, 32'd5, 32'd5, 0);
        run_op(3'd4, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(3'd6, 32'd3, 32'd5, 0);
        run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'd123, 32'd0, 0);
        run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(3'd3, 32'h8000_0000, 32'd1, 1);
        run_op(3'd5, 32'd0, 32'd0, 4);

        // Reset in the middle of a long multiply.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_a = 32'd1; req_b = 32'h8000_0000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("midrst_alu_ctl", {28'd0, alu_ctl}, 32'd0);
        check_eq("midrst_alu_b", alu_b, 32'd0);
        check_eq("midrst_result", rsp_result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        quiet_viol = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) quiet_viol++;
        end
        check_eq("no_rsp_after_reset", quiet_viol, 32'd0);

        for (int n = 0; n < 60; n++) begin
            rop = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            if (rop == 3'd6) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(rop, ra, rb, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
